// File: rtl/class_arbiter.sv
// class_arbiter: weighted round-robin egress scheduler.
// Moves one word at a time from four class FIFOs into a shared output FIFO
// using a fixed IDLE -> POP -> WAIT -> PUSH cycle. Per-class weights set the
// burst length a class may keep before the pointer moves on.
// Optional feature: define STRICT_CLASS0_EN to give class 0 strict priority
// over the weighted round-robin (class 0 grants leave pointer and credit as is).
//
// state  | meaning
// IDLE   | waiting for an eligible class and room in the output FIFO
// POP    | pop pulse issued to the granted class FIFO
// WAIT   | FIFO read latency; capture the word and raise push
// PUSH   | push pulse issued to the output FIFO; return to IDLE
module class_arbiter #(
    parameter int LINE_SIZE   = 12,
    parameter int WEIGHT_BITS = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [4*LINE_SIZE-1:0]   data_in,
    input  logic [3:0]               almost_empty_signal,
    input  logic                     almost_full_signal,
    input  logic [4*WEIGHT_BITS-1:0] weight_cfg,
    output logic [3:0]               pop_signal,
    output logic                     push_signal,
    output logic [LINE_SIZE-1:0]     data_out,
    output logic [1:0]               grant,
    output logic                     busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_POP,
        S_WAIT,
        S_PUSH
    } state_t;

    state_t                 state;
    logic [1:0]             ptr;
    logic [WEIGHT_BITS-1:0] cnt;

    logic [3:0]             elig;
    logic [1:0]             arb_w;
    logic [1:0]             arb_ptr;
    logic [WEIGHT_BITS-1:0] arb_cnt;
    logic [WEIGHT_BITS-1:0] wsel;
    logic [1:0]             cand;
    logic                   found;

    assign elig = ~almost_empty_signal;

    // Arbitration result for the current IDLE sample: winner plus next pointer/credit.
    always_comb begin
        arb_w   = ptr;
        arb_ptr = ptr;
        arb_cnt = cnt;
        wsel    = '0;
        cand    = '0;
        found   = 1'b0;
        if (elig[ptr] && cnt != '0) begin
            arb_cnt = cnt - 1'b1;
        end else begin
            // Search order ptr+1, ptr+2, ptr+3, ptr; any leftover credit is forfeited.
            for (int i = 1; i <= 4; i++) begin
                cand = ptr + 2'(i);
                if (!found && elig[cand]) begin
                    found = 1'b1;
                    arb_w = cand;
                end
            end
            wsel    = weight_cfg[arb_w*WEIGHT_BITS +: WEIGHT_BITS];
            arb_ptr = arb_w;
            // A weight of 0 behaves like 1, so the new burst credit is max(w,1)-1.
            arb_cnt = (wsel == '0) ? '0 : wsel - 1'b1;
        end
`ifdef STRICT_CLASS0_EN
        if (elig[0]) begin
            arb_w   = 2'd0;
            arb_ptr = ptr;
            arb_cnt = cnt;
        end
`endif
    end

    // Transfer sequencer with registered handshake outputs and arbitration state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            ptr         <= 2'd3;
            cnt         <= '0;
            pop_signal  <= 4'b0000;
            push_signal <= 1'b0;
            data_out    <= '0;
            grant       <= 2'd0;
            busy        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    pop_signal  <= 4'b0000;
                    push_signal <= 1'b0;
                    busy        <= 1'b0;
                    if (!almost_full_signal && (elig != 4'b0000)) begin
                        pop_signal <= 4'b0001 << arb_w;
                        grant      <= arb_w;
                        busy       <= 1'b1;
                        ptr        <= arb_ptr;
                        cnt        <= arb_cnt;
                        state      <= S_POP;
                    end
                end
                S_POP: begin
                    pop_signal <= 4'b0000;
                    state      <= S_WAIT;
                end
                S_WAIT: begin
                    data_out    <= data_in[grant*LINE_SIZE +: LINE_SIZE];
                    push_signal <= 1'b1;
                    state       <= S_PUSH;
                end
                S_PUSH: begin
                    push_signal <= 1'b0;
                    busy        <= 1'b0;
                    state       <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
